// File: rtl/echo_capture_ctrl.sv
// Echo acquisition sequencer: arm, wait for pulser trigger edge, delay, capture
// ADC samples into an external simple dual-port RAM, then stream them out.
module echo_capture_ctrl #(
   parameter int ASIZE = 13,
   parameter int DSIZE = 8,
   parameter int DLYW  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_trig,
   input  logic [DLYW-1:0]  i_delay,
   input  logic [ASIZE-1:0] i_len,
   input  logic [DSIZE-1:0] i_adc_data,
   input  logic             i_adc_valid,
   output logic             o_ram_we,
   output logic [ASIZE-1:0] o_ram_wr_addr,
   output logic [DSIZE-1:0] o_ram_wr_data,
   output logic [ASIZE-1:0] o_ram_rd_addr,
   input  logic [DSIZE-1:0] i_ram_q,
   output logic [DSIZE-1:0] o_rd_data,
   output logic             o_rd_valid,
   input  logic             i_rd_ready,
   output logic             o_busy,
   output logic             o_done
);

   // state   | meaning
   // IDLE    | waiting for i_start; pointers held at zero
   // ARMED   | delay/length latched; waiting for trigger rising edge
   // DELAY   | trigger seen; counting down the programmed delay
   // CAPTURE | writing valid ADC samples to RAM at wr_ptr
   // READOUT | presenting RAM word at rd_ptr on the valid/ready port
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      DELAY   = 3'd2,
      CAPTURE = 3'd3,
      READOUT = 3'd4
   } state_t;

   localparam logic [DLYW-1:0]  DLY_ONE  = DLYW'(1);
   localparam logic [ASIZE-1:0] ADDR_ONE = ASIZE'(1);

   state_t           state_q, state_d;
   logic             trig_q, trig_d;
   logic [DLYW-1:0]  dly_q, dly_d;
   logic [DLYW-1:0]  dly_cnt_q, dly_cnt_d;
   logic [ASIZE-1:0] len_q, len_d;
   logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;

   logic trig_edge;
   logic in_capture;
   logic in_readout;
   logic last_word;

   assign trig_edge  = i_trig & ~trig_q;
   assign in_capture = (state_q == CAPTURE);
   assign in_readout = (state_q == READOUT);
   assign last_word  = in_readout & i_rd_ready & (rd_ptr_q == len_q);

   always_comb begin
      state_d   = state_q;
      trig_d    = i_trig;
      dly_d     = dly_q;
      dly_cnt_d = dly_cnt_q;
      len_d     = len_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               dly_d    = i_delay;
               len_d    = i_len;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               state_d  = ARMED;
            end
         end
         ARMED: begin
            // A delay of 0 or 1 both land in CAPTURE the cycle after the edge;
            // longer delays enter CAPTURE exactly dly_q cycles after the edge.
            if (trig_edge) begin
               if (dly_q <= DLY_ONE) begin
                  state_d = CAPTURE;
               end else begin
                  dly_cnt_d = dly_q - DLY_ONE;
                  state_d   = DELAY;
               end
            end
         end
         DELAY: begin
            dly_cnt_d = dly_cnt_q - DLY_ONE;
            if (dly_cnt_q == DLY_ONE) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (i_adc_valid) begin
               if (wr_ptr_q == len_q) begin
                  wr_ptr_d = '0;
                  state_d  = READOUT;
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_ONE;
               end
            end
         end
         READOUT: begin
            if (i_rd_ready) begin
               if (rd_ptr_q == len_q) begin
                  rd_ptr_d = '0;
                  state_d  = IDLE;
               end else begin
                  rd_ptr_d = rd_ptr_q + ADDR_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides every other transition; pointers return to zero so
      // the read address reads 0 in IDLE.
      if (i_abort) begin
         state_d   = IDLE;
         dly_cnt_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         trig_q    <= 1'b0;
         dly_q     <= '0;
         dly_cnt_q <= '0;
         len_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         trig_q    <= trig_d;
         dly_q     <= dly_d;
         dly_cnt_q <= dly_cnt_d;
         len_q     <= len_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Write strobe stays combinational so a sample in the abort cycle still lands.
   assign o_ram_we      = in_capture & i_adc_valid;
   assign o_ram_wr_addr = in_capture ? wr_ptr_q : '0;
   assign o_ram_wr_data = in_capture ? i_adc_data : '0;
   assign o_ram_rd_addr = rd_ptr_q;
   assign o_rd_valid    = in_readout;
   assign o_rd_data     = in_readout ? i_ram_q : '0;
   assign o_busy        = (state_q != IDLE);
   assign o_done        = last_word & ~i_abort;

endmodule

// File: tb/tb_echo_capture_ctrl.sv
// Directed bench for echo_capture_ctrl with a behavioural 8K x 8 RAM
// (synchronous write, asynchronous read) attached to the RAM ports.
module tb_echo_capture_ctrl;
   localparam int ASIZE = 13;
   localparam int DSIZE = 8;
   localparam int DLYW  = 16;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b1;
   logic             i_start = 1'b0;
   logic             i_abort = 1'b0;
   logic             i_trig = 1'b0;
   logic [DLYW-1:0]  i_delay = '0;
   logic [ASIZE-1:0] i_len = '0;
   logic [DSIZE-1:0] i_adc_data = '0;
   logic             i_adc_valid = 1'b0;
   logic             o_ram_we;
   logic [ASIZE-1:0] o_ram_wr_addr;
   logic [DSIZE-1:0] o_ram_wr_data;
   logic [ASIZE-1:0] o_ram_rd_addr;
   logic [DSIZE-1:0] i_ram_q;
   logic [DSIZE-1:0] o_rd_data;
   logic             o_rd_valid;
   logic             i_rd_ready = 1'b0;
   logic             o_busy;
   logic             o_done;

   logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];

   int total = 0;
   int bad   = 0;

   echo_capture_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .DLYW(DLYW)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_trig       (i_trig),
      .i_delay      (i_delay),
      .i_len        (i_len),
      .i_adc_data   (i_adc_data),
      .i_adc_valid  (i_adc_valid),
      .o_ram_we     (o_ram_we),
      .o_ram_wr_addr(o_ram_wr_addr),
      .o_ram_wr_data(o_ram_wr_data),
      .o_ram_rd_addr(o_ram_rd_addr),
      .i_ram_q      (i_ram_q),
      .o_rd_data    (o_rd_data),
      .o_rd_valid   (o_rd_valid),
      .i_rd_ready   (i_rd_ready),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (o_ram_we) mem[o_ram_wr_addr] <= o_ram_wr_data;
   end
   assign i_ram_q = mem[o_ram_rd_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ctl"}, {o_busy, o_done, o_ram_we, o_rd_valid}, 64'h0);
      chk({tag, "_bus"}, {o_ram_wr_addr, o_ram_wr_data, o_ram_rd_addr, o_rd_data}, 64'h0);
   endtask

   task automatic arm(input logic [DLYW-1:0] dly, input logic [ASIZE-1:0] len);
      i_start = 1'b1;
      i_delay = dly;
      i_len   = len;
      tick();
      i_start = 1'b0;
   endtask

   // Expects CAPTURE on entry; one valid sample per cycle, data base+i at address i.
   task automatic capture_seq(input string tag, input logic [7:0] base, input int n);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = base + 8'(i);
         i_adc_valid = 1'b1;
         i_adc_data  = d;
         #1;
         chk(tag, {o_ram_we, o_ram_wr_addr, o_ram_wr_data}, {1'b1, 13'(i), d});
         tick();
      end
      i_adc_valid = 1'b0;
   endtask

   // Expects READOUT on entry; ready held high, done only on the last word.
   task automatic read_seq(input string tag, input logic [7:0] base, input int n);
      i_rd_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         chk(tag, {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data},
             {1'b1, (i == n - 1), 13'(i), 8'(base + 8'(i))});
         tick();
      end
      i_rd_ready = 1'b0;
      #1;
      chk({tag, "_end"}, {o_busy, o_rd_valid, o_ram_rd_addr}, 64'h0);
   endtask

   initial begin
      logic [ASIZE-1:0] a;
      logic [7:0]       d;

      // reset
      #3 i_rst_n = 1'b0;
      #1 chk_idle("rst");
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      chk_idle("rst_rel");

      // basic capture: delay 0, len 3
      arm(16'd0, 13'd3);
      chk("t1_armed_busy", o_busy, 1);
      i_trig = 1'b1;
      i_adc_valid = 1'b1;
      #1;
      chk("t1_edge_no_we", o_ram_we, 0);
      tick();
      capture_seq("t1_wr", 8'h10, 4);
      read_seq("t1_rd", 8'h10, 4);
      i_trig = 1'b0;
      tick();

      // delay 5, len 1, valid toggling; inputs changed after arming
      arm(16'd5, 13'd1);
      i_delay = 16'd0;
      i_len   = 13'd0;
      i_trig = 1'b1;
      i_adc_valid = 1'b1;
      i_adc_data  = 8'hEE;
      #1;
      chk("t2_edge_no_we", o_ram_we, 0);
      tick();
      for (int k = 1; k < 5; k++) begin
         #1;
         chk("t2_delay_no_we", {o_busy, o_ram_we}, 2'b10);
         tick();
      end
      i_adc_data = 8'hA0;
      #1;
      chk("t2_wr0", {o_ram_we, o_ram_wr_addr, o_ram_wr_data}, {1'b1, 13'd0, 8'hA0});
      tick();
      i_adc_valid = 1'b0;
      i_adc_data  = 8'hA1;
      #1;
      chk("t2_gap", {o_ram_we, o_busy, o_rd_valid}, 3'b010);
      tick();
      i_adc_valid = 1'b1;
      i_adc_data  = 8'hA2;
      #1;
      chk("t2_wr1", {o_ram_we, o_ram_wr_addr, o_ram_wr_data}, {1'b1, 13'd1, 8'hA2});
      tick();
      i_adc_valid = 1'b0;
      i_rd_ready = 1'b1;
      #1;
      chk("t2_rd0", {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data}, {1'b1, 1'b0, 13'd0, 8'hA0});
      tick();
      #1;
      chk("t2_rd1", {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data}, {1'b1, 1'b1, 13'd1, 8'hA2});
      tick();
      i_rd_ready = 1'b0;
      i_trig = 1'b0;
      #1;
      chk("t2_end_busy", o_busy, 0);
      tick();

      // backpressure: len 4, ready low for 3 cycles after the first word
      arm(16'd0, 13'd4);
      i_trig = 1'b1;
      tick();
      capture_seq("t3_wr", 8'h30, 5);
      i_trig = 1'b0;
      i_rd_ready = 1'b1;
      #1;
      chk("t3_rd0", {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data}, {1'b1, 1'b0, 13'd0, 8'h30});
      tick();
      i_rd_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_stall", {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data}, {1'b1, 1'b0, 13'd1, 8'h31});
         tick();
      end
      i_rd_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         #1;
         chk("t3_rd", {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data},
             {1'b1, (i == 4), 13'(i), 8'(8'h30 + 8'(i))});
         tick();
      end
      i_rd_ready = 1'b0;
      #1;
      chk("t3_end_busy", o_busy, 0);

      // trigger rising together with start in IDLE, then held high while armed
      i_start = 1'b1;
      i_delay = 16'd0;
      i_len   = 13'd0;
      i_trig  = 1'b1;
      tick();
      i_start = 1'b0;
      i_adc_valid = 1'b1;
      i_adc_data  = 8'h55;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_held_no_cap", {o_busy, o_ram_we}, 2'b10);
         tick();
      end
      i_trig = 1'b0;
      #1;
      chk("t4_low_no_cap", {o_busy, o_ram_we}, 2'b10);
      tick();
      i_trig = 1'b1;
      #1;
      chk("t4_edge_no_we", o_ram_we, 0);
      tick();
      #1;
      chk("t4_wr", {o_ram_we, o_ram_wr_addr, o_ram_wr_data}, {1'b1, 13'd0, 8'h55});
      tick();
      i_adc_valid = 1'b0;
      i_trig = 1'b0;
      read_seq("t4_rd", 8'h55, 1);
      tick();

      // abort in DELAY
      arm(16'd10, 13'd3);
      i_trig = 1'b1;
      tick();
      tick();
      i_abort = 1'b1;
      #1;
      chk("t5a_pre", {o_busy, o_done, o_ram_we}, 3'b100);
      tick();
      i_abort = 1'b0;
      i_trig = 1'b0;
      chk_idle("t5a_idle");
      tick();

      // abort in CAPTURE at wr_ptr 2: the abort-cycle write still lands
      arm(16'd0, 13'd5);
      i_trig = 1'b1;
      tick();
      capture_seq("t5b_wr", 8'h60, 2);
      i_adc_valid = 1'b1;
      i_adc_data  = 8'h62;
      i_abort     = 1'b1;
      #1;
      chk("t5b_abort_wr", {o_ram_we, o_ram_wr_addr, o_ram_wr_data, o_done}, {1'b1, 13'd2, 8'h62, 1'b0});
      tick();
      i_abort = 1'b0;
      i_adc_valid = 1'b0;
      i_trig = 1'b0;
      chk_idle("t5b_idle");
      chk("t5b_mem2", mem[2], 8'h62);
      tick();

      // abort in READOUT on the final word: no done
      arm(16'd0, 13'd1);
      i_trig = 1'b1;
      tick();
      capture_seq("t5c_wr", 8'h70, 2);
      i_rd_ready = 1'b1;
      #1;
      chk("t5c_rd0", {o_rd_valid, o_ram_rd_addr, o_rd_data}, {1'b1, 13'd0, 8'h70});
      tick();
      i_abort = 1'b1;
      #1;
      chk("t5c_abort_no_done", {o_rd_valid, o_done, o_ram_rd_addr}, {1'b1, 1'b0, 13'd1});
      tick();
      i_abort = 1'b0;
      i_rd_ready = 1'b0;
      i_trig = 1'b0;
      chk_idle("t5c_idle");
      tick();

      // reset mid-capture, then a fresh record
      arm(16'd0, 13'd5);
      i_trig = 1'b1;
      tick();
      i_adc_valid = 1'b1;
      i_adc_data  = 8'h90;
      tick();
      i_adc_data  = 8'h91;
      tick();
      i_rst_n = 1'b0;
      #1;
      chk_idle("t5d_rst");
      i_adc_valid = 1'b0;
      i_trig = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      arm(16'd0, 13'd1);
      i_trig = 1'b1;
      tick();
      capture_seq("t5d_wr", 8'h80, 2);
      i_trig = 1'b0;
      read_seq("t5d_rd", 8'h80, 2);
      tick();

      // full depth
      arm(16'd0, 13'd8191);
      i_trig = 1'b1;
      tick();
      i_trig = 1'b0;
      for (int i = 0; i < 8192; i++) begin
         a = 13'(i);
         d = a[7:0] ^ 8'h5A;
         i_adc_valid = 1'b1;
         i_adc_data  = d;
         #1;
         chk("t6_wr", {o_ram_we, o_ram_wr_addr, o_ram_wr_data}, {1'b1, a, d});
         tick();
      end
      i_adc_valid = 1'b0;
      i_rd_ready = 1'b1;
      for (int i = 0; i < 8192; i++) begin
         a = 13'(i);
         d = a[7:0] ^ 8'h5A;
         #1;
         chk("t6_rd", {o_rd_valid, o_done, o_ram_rd_addr, o_rd_data}, {1'b1, (i == 8191), a, d});
         tick();
      end
      i_rd_ready = 1'b0;
      #1;
      chk_idle("t6_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
